sn_stream_decoder: RTL and testbench
====================================

Name: sn_stream_decoder

Overview:
- Receive end of the stochastic-number link: accepts a serial stochastic bitstream (one bit per qualified cycle) from an on-chip multiplier or an external pin.
- Counts ones over a fixed window of 2^WIN_LOG2 bits and converts the count to a binary value, unipolar or bipolar.
- Sits between the SN source and the uo_out/readout logic.
- Replaces free-running clock-window counting with qualified bits, explicit start/done handshake, saturation and back-to-back windows.

Parameters:
WIN_LOG2, 7, window length N = 2^WIN_LOG2 accepted bits (legal 2..12)
OUT_W, 8, width of value_out (legal 2..16)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-high
clear  in  1  synchronous abort; returns to IDLE, discards partial window
start  in  1  begin a window (IDLE only)
auto_restart  in  1  sampled at start; 1 = windows run back-to-back until clear
bipolar  in  1  sampled at start; 0 = unipolar, 1 = bipolar
sn_valid  in  1  sn_bit qualifier
sn_bit  in  1  stochastic bit
busy  out  1  high in ACCUM
done  out  1  one-cycle pulse, results updated
value_out  out  OUT_W  converted value; two's complement when bipolar; held between done pulses
count_out  out  WIN_LOG2+1  raw ones count of last window, 0..N
sat  out  1  value_out saturated in last window

Behaviour:
- Reset: state IDLE; busy=0, done=0, value_out=0, count_out=0, sat=0; internal ones_cnt=0, bit_cnt=0, mode regs=0.
- FSM, two states:
  - IDLE: start=1 -> ACCUM; clear ones_cnt/bit_cnt; latch bipolar into mode_bip and auto_restart into mode_ar.
  - ACCUM: each cycle with sn_valid=1, bit_cnt += 1 and ones_cnt += sn_bit. Cycles with sn_valid=0 change nothing; there is no timeout.
  - start in ACCUM is ignored.
- Last bit: the accepted bit where bit_cnt == N-1 before the edge. Its sn_bit is included in the final count.
- At the edge that accepts the last bit:
  - count_out <= final ones; value_out and sat updated; done <= 1 for exactly one cycle.
  - Results appear the cycle after the last bit, so latency is 1.
  - mode_ar=0 -> IDLE, busy=0.
  - mode_ar=1 -> stay ACCUM with counters cleared. The next accepted bit is bit 0 of the new window: no gap, no lost bit. Mode regs are not re-sampled.
- Width rules:
  - ones_cnt and bit_cnt are WIN_LOG2+1 bits; ones_cnt never wraps (max N).
- Conversion, with c = final ones count:
  - Unipolar: value = c. If c > 2^OUT_W - 1, value = 2^OUT_W - 1 and sat=1.
  - Bipolar: v = 2c - N, computed signed at WIN_LOG2+2 bits. Clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and set sat=1 when clamped.
  - sat is otherwise 0 on every done.
- clear (priority over start and sn_valid): state IDLE, counters cleared, done=0 that cycle. value_out, count_out and sat hold their last results.
- Last bit and clear in the same cycle: clear wins, no done.
- Asynchronous reset mid-window: immediate return to reset values, no done.
- done is registered and never asserted in two consecutive cycles when N ≥ 2.

Test Plan:
- Reset, start, bipolar=0, 128 valid bits with ones at indices 0..63 -> one cycle after bit 127: done=1 for one cycle, count_out=64, value_out=64, sat=0, busy=0.
- bipolar=1, 96 ones in 128 -> value_out=0x40 (+64). 0 ones -> 0x80 (-128), sat=0. 128 ones -> 0x7F, sat=1, count_out=128.
- sn_valid toggled 1/0 every cycle, all bits 1 -> done exactly 256 cycles after start, count_out=128. Bits presented with sn_valid=0 are not counted.
- auto_restart=1, 3 windows streamed without sn_valid gaps, 32/64/128 ones (unipolar) -> three done pulses 128 cycles apart, count_out 32/64/128, busy stays 1.
- clear at bit 50, then start with 128 zeros -> no done until the new window ends; value_out holds the prior value until done, then 0. clear on the last-bit cycle -> no done.
- rst_n pulsed mid-window -> all outputs 0 asynchronously, IDLE, start ignored while rst_n high.

Source files
------------

// File: rtl/sn_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module   : sn_stream_decoder
// Brief    : Counts ones over a 2^WIN_LOG2-bit window of a qualified
//            stochastic bitstream and converts the count to a unipolar or
//            bipolar binary value, with saturation and back-to-back windows.
// Revision : 1.0
// ============================================================================
module sn_stream_decoder #(
    parameter int WIN_LOG2 = 7,
    parameter int OUT_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                start,
    input  logic                auto_restart,
    input  logic                bipolar,
    input  logic                sn_valid,
    input  logic                sn_bit,
    output logic                busy,
    output logic                done,
    output logic [OUT_W-1:0]    value_out,
    output logic [WIN_LOG2:0]   count_out,
    output logic                sat
);

    localparam int CW = WIN_LOG2 + 1;
    // Wide enough for 2c-N and for both clamp bounds without overflow.
    localparam int VW = ((WIN_LOG2 + 2 > OUT_W) ? (WIN_LOG2 + 2) : OUT_W) + 1;

    localparam logic [CW-1:0]        c_LAST_IDX = CW'((1 << WIN_LOG2) - 1);
    localparam logic [VW-1:0]        c_UMAX     = VW'((1 << OUT_W) - 1);
    localparam logic signed [VW-1:0] c_BMAX     = VW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [VW-1:0] c_BMIN     = ~c_BMAX;
    localparam logic signed [VW-1:0] c_N        = VW'(1 << WIN_LOG2);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    state_t                 state_q;
    logic [CW-1:0]          ones_q;
    logic [CW-1:0]          bits_q;
    logic                   mode_bip_q;
    logic                   mode_ar_q;
    logic                   done_q;
    logic [OUT_W-1:0]       value_q;
    logic [CW-1:0]          count_q;
    logic                   sat_q;

    logic [CW-1:0]          ones_d;
    logic [VW-1:0]          c_ext;
    logic [VW-1:0]          c_twice;
    logic signed [VW-1:0]   v_bip;
    logic [OUT_W-1:0]       value_d;
    logic                   sat_d;
    logic                   last_bit;

    // Conversion works on the count including the bit accepted this cycle.
    always_comb begin
        ones_d   = ones_q + CW'(sn_bit);
        c_ext    = VW'(ones_d);
        c_twice  = c_ext << 1;
        v_bip    = signed'(c_twice) - c_N;
        value_d  = c_ext[OUT_W-1:0];
        sat_d    = 1'b0;
        last_bit = (bits_q == c_LAST_IDX);
        if (mode_bip_q) begin
            if (v_bip > c_BMAX) begin
                value_d = c_BMAX[OUT_W-1:0];
                sat_d   = 1'b1;
            end else if (v_bip < c_BMIN) begin
                value_d = c_BMIN[OUT_W-1:0];
                sat_d   = 1'b1;
            end else begin
                value_d = v_bip[OUT_W-1:0];
            end
        end else if (c_ext > c_UMAX) begin
            value_d = c_UMAX[OUT_W-1:0];
            sat_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= S_IDLE;
            ones_q     <= '0;
            bits_q     <= '0;
            mode_bip_q <= 1'b0;
            mode_ar_q  <= 1'b0;
            done_q     <= 1'b0;
            value_q    <= '0;
            count_q    <= '0;
            sat_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (clear) begin
                state_q <= S_IDLE;
                ones_q  <= '0;
                bits_q  <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q    <= S_ACCUM;
                            ones_q     <= '0;
                            bits_q     <= '0;
                            mode_bip_q <= bipolar;
                            mode_ar_q  <= auto_restart;
                        end
                    end
                    S_ACCUM: begin
                        if (sn_valid) begin
                            if (last_bit) begin
                                count_q <= ones_d;
                                value_q <= value_d;
                                sat_q   <= sat_d;
                                done_q  <= 1'b1;
                                ones_q  <= '0;
                                bits_q  <= '0;
                                if (!mode_ar_q) begin
                                    state_q <= S_IDLE;
                                end
                            end else begin
                                ones_q <= ones_d;
                                bits_q <= bits_q + CW'(1);
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign busy      = (state_q == S_ACCUM);
    assign done      = done_q;
    assign value_out = value_q;
    assign count_out = count_q;
    assign sat       = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_sn_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sn_stream_decoder
// Brief    : Self-checking bench for sn_stream_decoder (WIN_LOG2=7, OUT_W=8).
// Revision : 1.0
// ============================================================================
module tb_sn_stream_decoder;

    localparam int WIN_LOG2 = 7;
    localparam int OUT_W    = 8;
    localparam int N        = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic clear = 1'b0;
    logic start = 1'b0;
    logic auto_restart = 1'b0;
    logic bipolar = 1'b0;
    logic sn_valid = 1'b0;
    logic sn_bit = 1'b0;
    logic busy;
    logic done;
    logic [OUT_W-1:0]  value_out;
    logic [WIN_LOG2:0] count_out;
    logic sat;

    int checks = 0;
    int failures = 0;
    bit win [N];
    logic [OUT_W-1:0]  held_val;
    logic [WIN_LOG2:0] held_cnt;

    sn_stream_decoder #(.WIN_LOG2(WIN_LOG2), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .start(start),
        .auto_restart(auto_restart), .bipolar(bipolar),
        .sn_valid(sn_valid), .sn_bit(sn_bit),
        .busy(busy), .done(done), .value_out(value_out),
        .count_out(count_out), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference conversion straight from the arithmetic definition.
    function automatic void model(input int c, input bit bip,
                                  output logic [OUT_W-1:0] val, output bit s);
        int v;
        s = 1'b0;
        v = bip ? (2 * c - N) : c;
        if (bip) begin
            if (v > 127)  begin v = 127;  s = 1'b1; end
            if (v < -128) begin v = -128; s = 1'b1; end
        end else if (v > 255) begin
            v = 255; s = 1'b1;
        end
        val = 8'(v & 255);
    endfunction

    task automatic make_window(input int k);
        for (int i = 0; i < N; i++) win[i] = (i < k);
        for (int i = N - 1; i > 0; i--) begin
            int j;
            bit t;
            j = $urandom_range(i, 0);
            t = win[i]; win[i] = win[j]; win[j] = t;
        end
    endtask

    task automatic do_start(input bit bip, input bit ar);
        start = 1'b1; bipolar = bip; auto_restart = ar; sn_valid = 1'b0;
        tick();
        start = 1'b0; bipolar = 1'b0; auto_restart = 1'b0;
    endtask

    // Streams n bits of win[] with no gaps; counts done pulses before bit N-1.
    task automatic feed_window(input int n, output int early);
        early = 0;
        for (int i = 0; i < n; i++) begin
            sn_valid = 1'b1; sn_bit = win[i];
            tick();
            if (i < N - 1 && done === 1'b1) early++;
        end
        sn_valid = 1'b0; sn_bit = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (value_out !== 8'd0) begin failures++; $display("FAIL reset_value got=%0h exp=0", value_out); end
        checks++; if (count_out !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_out); end
        checks++; if (sat !== 1'b0) begin failures++; $display("FAIL reset_sat got=%0b exp=0", sat); end
        rst_n = 1'b0;
        tick();
    endtask

    task automatic test_unipolar_half();
        int early;
        do_start(1'b0, 1'b0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL uni_busy_start got=%0b exp=1", busy); end
        for (int i = 0; i < N; i++) win[i] = (i < 64);
        feed_window(N, early);
        checks++; if (early !== 0) begin failures++; $display("FAIL uni_early_done got=%0d exp=0", early); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL uni_done got=%0b exp=1", done); end
        checks++; if (count_out !== 8'd64) begin failures++; $display("FAIL uni_count got=%0d exp=64", count_out); end
        checks++; if (value_out !== 8'd64) begin failures++; $display("FAIL uni_value got=%0d exp=64", value_out); end
        checks++; if (sat !== 1'b0) begin failures++; $display("FAIL uni_sat got=%0b exp=0", sat); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL uni_busy_end got=%0b exp=0", busy); end
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL uni_done_pulse got=%0b exp=0", done); end
    endtask

    task automatic test_bipolar_edges();
        int ks [3] = '{96, 0, 128};
        int early;
        logic [OUT_W-1:0] ev;
        bit es;
        for (int t = 0; t < 3; t++) begin
            make_window(ks[t]);
            model(ks[t], 1'b1, ev, es);
            do_start(1'b1, 1'b0);
            feed_window(N, early);
            checks++; if (early !== 0) begin failures++; $display("FAIL bip_early k=%0d got=%0d exp=0", ks[t], early); end
            checks++; if (done !== 1'b1) begin failures++; $display("FAIL bip_done k=%0d got=%0b exp=1", ks[t], done); end
            checks++; if (value_out !== ev) begin failures++; $display("FAIL bip_value k=%0d got=%0h exp=%0h", ks[t], value_out, ev); end
            checks++; if (sat !== es) begin failures++; $display("FAIL bip_sat k=%0d got=%0b exp=%0b", ks[t], sat, es); end
            checks++; if (count_out !== 8'(ks[t])) begin failures++; $display("FAIL bip_count k=%0d got=%0d exp=%0d", ks[t], count_out, ks[t]); end
            tick();
        end
    endtask

    task automatic test_random();
        for (int w = 0; w < 6; w++) begin
            bit bip;
            int ones;
            int early;
            int thr;
            logic [OUT_W-1:0] ev;
            bit es;
            bip = 1'($urandom_range(1, 0));
            thr = $urandom_range(100, 0);
            ones = 0; early = 0;
            do_start(bip, 1'b0);
            for (int i = 0; i < N; i++) begin
                int gap;
                gap = $urandom_range(2, 0);
                for (int g = 0; g < gap; g++) begin
                    sn_valid = 1'b0; sn_bit = 1'($urandom_range(1, 0));
                    tick();
                    if (done === 1'b1) early++;
                end
                sn_valid = 1'b1;
                sn_bit = ($urandom_range(99, 0) < thr);
                if (sn_bit) ones++;
                tick();
                if (i < N - 1 && done === 1'b1) early++;
            end
            sn_valid = 1'b0;
            model(ones, bip, ev, es);
            checks++; if (early !== 0) begin failures++; $display("FAIL rnd_early w=%0d got=%0d exp=0", w, early); end
            checks++; if (done !== 1'b1) begin failures++; $display("FAIL rnd_done w=%0d got=%0b exp=1", w, done); end
            checks++; if (count_out !== 8'(ones)) begin failures++; $display("FAIL rnd_count w=%0d got=%0d exp=%0d", w, count_out, ones); end
            checks++; if (value_out !== ev) begin failures++; $display("FAIL rnd_value w=%0d bip=%0b got=%0h exp=%0h", w, bip, value_out, ev); end
            checks++; if (sat !== es) begin failures++; $display("FAIL rnd_sat w=%0d got=%0b exp=%0b", w, sat, es); end
            tick();
        end
    endtask

    task automatic test_valid_toggle();
        int edges;
        bit seen;
        edges = 0; seen = 1'b0;
        do_start(1'b0, 1'b0);
        while (!seen && edges < 400) begin
            sn_valid = (edges % 2 == 0);
            sn_bit = 1'b1;
            tick();
            edges++;
            if (done === 1'b1) seen = 1'b1;
        end
        sn_valid = 1'b0; sn_bit = 1'b0;
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL tog_timeout got=%0b exp=1", seen); end
        checks++; if (edges !== 255) begin failures++; $display("FAIL tog_latency got=%0d exp=255", edges); end
        checks++; if (count_out !== 8'd128) begin failures++; $display("FAIL tog_count got=%0d exp=128", count_out); end
        tick();
    endtask

    task automatic test_back_to_back();
        int ks [3] = '{32, 64, 128};
        int bad_busy;
        int bad_done;
        bad_busy = 0; bad_done = 0;
        do_start(1'b0, 1'b1);
        for (int w = 0; w < 3; w++) begin
            logic [OUT_W-1:0] ev;
            bit es;
            make_window(ks[w]);
            model(ks[w], 1'b0, ev, es);
            for (int i = 0; i < N; i++) begin
                sn_valid = 1'b1; sn_bit = win[i];
                tick();
                if (busy !== 1'b1) bad_busy++;
                if (i < N - 1 && done === 1'b1) bad_done++;
            end
            checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done w=%0d got=%0b exp=1", w, done); end
            checks++; if (count_out !== 8'(ks[w])) begin failures++; $display("FAIL b2b_count w=%0d got=%0d exp=%0d", w, count_out, ks[w]); end
            checks++; if (value_out !== ev) begin failures++; $display("FAIL b2b_value w=%0d got=%0d exp=%0d", w, value_out, ev); end
        end
        sn_valid = 1'b0;
        checks++; if (bad_busy !== 0) begin failures++; $display("FAIL b2b_busy_drop got=%0d exp=0", bad_busy); end
        checks++; if (bad_done !== 0) begin failures++; $display("FAIL b2b_extra_done got=%0d exp=0", bad_done); end
        tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy_after got=%0b exp=1", busy); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_clear_busy got=%0b exp=0", busy); end
        checks++; if (value_out !== 8'd128) begin failures++; $display("FAIL b2b_clear_hold got=%0d exp=128", value_out); end
        held_val = 8'd128; held_cnt = 8'd128;
    endtask

    task automatic test_clear();
        int early;
        int bad_hold;
        do_start(1'b0, 1'b0);
        make_window(90);
        feed_window(50, early);
        sn_valid = 1'b1; sn_bit = 1'b1; clear = 1'b1;
        tick();
        clear = 1'b0; sn_valid = 1'b0;
        checks++; if (early !== 0) begin failures++; $display("FAIL clr_early got=%0d exp=0", early); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clr_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL clr_done got=%0b exp=0", done); end
        checks++; if (value_out !== held_val) begin failures++; $display("FAIL clr_value_hold got=%0d exp=%0d", value_out, held_val); end
        checks++; if (count_out !== held_cnt) begin failures++; $display("FAIL clr_count_hold got=%0d exp=%0d", count_out, held_cnt); end
        do_start(1'b0, 1'b0);
        bad_hold = 0; early = 0;
        for (int i = 0; i < N; i++) begin
            sn_valid = 1'b1; sn_bit = 1'b0;
            tick();
            if (i < N - 1) begin
                if (done === 1'b1) early++;
                if (value_out !== held_val) bad_hold++;
            end
        end
        sn_valid = 1'b0;
        checks++; if (early !== 0) begin failures++; $display("FAIL clr_new_early got=%0d exp=0", early); end
        checks++; if (bad_hold !== 0) begin failures++; $display("FAIL clr_new_hold got=%0d exp=0", bad_hold); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL clr_new_done got=%0b exp=1", done); end
        checks++; if (value_out !== 8'd0) begin failures++; $display("FAIL clr_new_value got=%0d exp=0", value_out); end
        tick();
        do_start(1'b1, 1'b0);
        make_window(128);
        feed_window(N - 1, early);
        sn_valid = 1'b1; sn_bit = 1'b1; clear = 1'b1;
        tick();
        clear = 1'b0; sn_valid = 1'b0;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL clr_last_done got=%0b exp=0", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clr_last_busy got=%0b exp=0", busy); end
        checks++; if (value_out !== 8'd0) begin failures++; $display("FAIL clr_last_value got=%0h exp=0", value_out); end
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL clr_last_late got=%0b exp=0", done); end
    endtask

    task automatic test_async_reset();
        int early;
        do_start(1'b0, 1'b1);
        make_window(128);
        feed_window(N, early);
        checks++; if (value_out !== 8'd128) begin failures++; $display("FAIL ar_pre_value got=%0d exp=128", value_out); end
        make_window(40);
        feed_window(40, early);
        #2;
        rst_n = 1'b1;
        #1;
        checks++; if (value_out !== 8'd0) begin failures++; $display("FAIL ar_value got=%0d exp=0", value_out); end
        checks++; if (count_out !== 8'd0) begin failures++; $display("FAIL ar_count got=%0d exp=0", count_out); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ar_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL ar_done got=%0b exp=0", done); end
        start = 1'b1; sn_valid = 1'b1; sn_bit = 1'b1;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ar_start_ignored got=%0b exp=0", busy); end
        start = 1'b0; sn_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ar_release_busy got=%0b exp=0", busy); end
        checks++; if (sat !== 1'b0) begin failures++; $display("FAIL ar_sat got=%0b exp=0", sat); end
    endtask

    initial begin
        held_val = '0;
        held_cnt = '0;
        test_reset();
        test_unipolar_half();
        test_bipolar_edges();
        test_random();
        test_valid_toggle();
        test_back_to_back();
        test_clear();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
